oled_spi_byte_master: RTL and testbench

//  Byte-wide SPI master (mode 3, MSB first) that drives the Pmod OLED serial pins.
//  It is fed one byte at a time by the OLED power-on/init sequencer over a start/done handshake.
//  It registers a data/command flag with each byte and drives it on oled DC for the whole frame.

---
 rtl/oled_spi_byte_master.sv | 145 ++++++++++++++
 tb/tb_oled_spi_byte_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_byte_master.sv
// oled_spi_byte_master: mode-3 MSB-first SPI byte master for the Pmod OLED, one byte per start/done handshake.
module oled_spi_byte_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       dc_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs,
    output logic       dc
);
    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("CLK_DIV must be >= 1");
        end
        if (CS_GAP < 1) begin : g_bad_gap
            $error("CS_GAP must be >= 1");
        end
    endgenerate

    localparam int MX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    half_q, half_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
    logic          cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic          dc_q, dc_d, busy_q, busy_d, done_q, done_d;
    logic          div_end, gap_end;

    assign div_end = cnt_q == CW'(CLK_DIV - 1);
    assign gap_end = cnt_q == CW'(CS_GAP - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        half_d     = half_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        dc_d       = dc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                half_d = '0;
                if (start) begin
                    tx_d    = data_in;
                    dc_d    = dc_in;
                    cs_d    = 1'b0;
                    mosi_d  = data_in[7];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: if (div_end) begin
                cnt_d   = '0;
                sclk_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: if (div_end) begin
                // Even half counts end with a rising edge; the final half-period just hands over to HOLD.
                cnt_d  = '0;
                half_d = half_q + 1'b1;
                if (half_q == 4'd15) begin
                    state_d = HOLD;
                end else if (!half_q[0]) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[6:0], 1'b0};
                    mosi_d = tx_q[6];
                end
            end
            HOLD: if (div_end) begin
                cnt_d   = '0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = GAP;
            end
            GAP: if (gap_end) begin
                cnt_d      = '0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                data_out_d = rx_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            dc_q       <= dc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;
    assign dc       = dc_q;
endmodule

// File: tb/tb_oled_spi_byte_master.sv
// tb_oled_spi_byte_master: frame-level reference checks of the SPI byte master at CLK_DIV=2 and CLK_DIV=1.
module tb_oled_spi_byte_master;
    localparam int GAPC = 2;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, dc_in = 1'b0, loop = 1'b0, sel = 1'b0;
    logic [7:0] data_in = 8'h00, mb = 8'h00, mbs;
    int         rc = 0;
    int         errors = 0, checks = 0;

    logic       busy2, done2, sclk2, mosi2, cs2, dc2, miso2;
    logic       busy1, done1, sclk1, mosi1, cs1, dc1, miso1;
    logic [7:0] do2, do1;
    logic       busy, done, sclk, mosi, cs, dc;
    logic [7:0] data_out;

    // The slave model presents its byte MSB first, advancing after every observed rising sclk.
    assign mbs   = mb << rc;
    assign miso2 = loop ? mosi2 : mbs[7];
    assign miso1 = loop ? mosi1 : mbs[7];

    assign busy     = sel ? busy1 : busy2;
    assign done     = sel ? done1 : done2;
    assign sclk     = sel ? sclk1 : sclk2;
    assign mosi     = sel ? mosi1 : mosi2;
    assign cs       = sel ? cs1 : cs2;
    assign dc       = sel ? dc1 : dc2;
    assign data_out = sel ? do1 : do2;

    oled_spi_byte_master #(.CLK_DIV(2), .CS_GAP(GAPC)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .dc_in(dc_in),
        .busy(busy2), .done(done2), .data_out(do2), .sclk(sclk2), .mosi(mosi2),
        .miso(miso2), .cs(cs2), .dc(dc2)
    );

    oled_spi_byte_master #(.CLK_DIV(1), .CS_GAP(GAPC)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .dc_in(dc_in),
        .busy(busy1), .done(done1), .data_out(do1), .sclk(sclk1), .mosi(mosi1),
        .miso(miso1), .cs(cs1), .dc(dc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge with start/data_in/dc_in already asserted for the frame.
    task automatic frame(input int d, input logic [7:0] b, input logic dcv, input logic lp,
                         input logic [7:0] m, input int inj, input logic chain,
                         input logic [7:0] nb, input logic ndc);
        int nrise = 0, ncs = 0, bad_dc = 0, bad_rise = 0, bad_busy = 0, ndone = 0;
        logic [7:0] got = 8'h00, exp;
        logic ps = 1'b1, fin = 1'b0;
        exp  = lp ? b : m;
        loop = lp;
        mb   = m;
        rc   = 0;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'($urandom);
        dc_in   = 1'($urandom);
        for (int t = 0; t < 400 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            if (t == inj - 1) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end else if (t == inj) start = 1'b0;
            if (done) begin
                fin = 1'b1;
                chk("done_time", t, 18 * d + GAPC);
                chk("done_busy", busy, 0);
                chk("done_cs", cs, 1);
                chk("data_out", data_out, exp);
            end else if (!busy) bad_busy++;
            if (!cs) begin
                ncs++;
                if (dc !== dcv) bad_dc++;
            end
            if (sclk && !ps) begin
                if (nrise < 8) got[7 - nrise] = mosi;
                if (t != (2 * nrise + 2) * d) bad_rise++;
                nrise++;
                rc = nrise;
            end
            ps = sclk;
        end
        if (!fin) chk("done_timeout", 0, 1);
        chk("rises", nrise, 8);
        chk("mosi_bits", got, b);
        chk("cs_low", ncs, 18 * d);
        chk("dc_hold", bad_dc, 0);
        chk("rise_time", bad_rise, 0);
        chk("busy_frame", bad_busy, 0);
        if (chain) begin
            start   = 1'b1;
            data_in = nb;
            dc_in   = ndc;
        end else begin
            repeat (4) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("single_done", ndone, 0);
            chk("data_held", data_out, exp);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic go(input int d, input logic [7:0] b, input logic dcv, input logic lp,
                      input logic [7:0] m, input int inj);
        start   = 1'b1;
        data_in = b;
        dc_in   = dcv;
        frame(d, b, dcv, lp, m, inj, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_cs", cs, 1);
            chk("rst_sclk", sclk, 1);
            chk("rst_mosi", mosi, 0);
            chk("rst_dc", dc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_data_out", data_out, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        go(2, 8'hA5, 1'b0, 1'b0, 8'($urandom), -1);
        go(2, 8'h3C, 1'b1, 1'b1, 8'h00, -1);

        start = 1'b1; data_in = 8'h8D; dc_in = 1'b0;
        frame(2, 8'h8D, 1'b0, 1'b0, 8'h5E, -1, 1'b1, 8'h14, 1'b1);
        frame(2, 8'h14, 1'b1, 1'b1, 8'h00, -1, 1'b0, 8'h00, 1'b0);

        go(2, 8'h5A, 1'b1, 1'b0, 8'h81, 10);

        start = 1'b1; data_in = 8'h96; dc_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_cs", cs, 1);
        chk("mrst_sclk", sclk, 1);
        chk("mrst_mosi", mosi, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_data_out", data_out, 0);
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mrst_no_done", nd, 0);
        go(2, 8'h69, 1'b0, 1'b0, 8'hC7, -1);

        repeat (6) go(2, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), -1);

        reset_pulse();
        sel = 1'b1;
        @(negedge clk);
        go(1, 8'hC3, 1'b1, 1'b0, 8'hFF, -1);
        repeat (4) go(1, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
